ln_series_ctrl: RTL and testbench
=================================

// Module: ln_series_ctrl
// PURPOSE
//   Sequencer for the ln(1+x) Maclaurin datapath: ln(1+x) = x - x^2/2 + x^3/3 - ...
//   Accepts x (unsigned Q0.16, 0 <= x < 1) on a start/busy/done handshake.
//   Drives the external reciprocal-coefficient LUT via coef_addr/coef_data.
//   Iterates power, coefficient multiply and signed accumulate; returns a Q0.16 result.
// PARAMETERS
//   DATA_W   16  width of x, coefficient, power and result (Q0.DATA_W)
//   N_TERMS  8   series terms summed, 1..9; term k uses LUT addr k-2 (addr 7 = 1/9 slot)
//   ADDR_W   3   LUT address width
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        request; accepted only in IDLE
//   x_in       in   DATA_W   operand, sampled on the accepting edge
//   coef_addr  out  ADDR_W   LUT address, registered
//   coef_data  in   DATA_W   LUT value, combinational from coef_addr (1/(k) in Q0.16)
//   busy       out  1        high while not IDLE
//   done       out  1        one-cycle pulse, result valid
//   result     out  DATA_W   ln(1+x), held until next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0, coef_addr=0, internal regs=0.
//   Internal: x_r, pow (DATA_W), acc signed DATA_W+2, k counter 2..N_TERMS.
//   IDLE : start=1 -> x_r<=x_in, pow<=x_in, acc<=x_in, k<=2; next POW (DONE if N_TERMS==1).
//          start ignored in every other state (no queueing).
//   POW  : pow <= (pow*x_r)>>DATA_W (truncate); coef_addr <= k-2; next TERM.
//   TERM : term = (pow*coef_data)>>DATA_W (truncate); k even: acc-=term, k odd: acc+=term.
//          k==N_TERMS -> DONE, else k++ -> POW.
//   DONE : done=1, result<=acc[DATA_W-1:0] (clamped to 0..2^DATA_W-1); next IDLE.
//   Latency: accepting edge = edge 0; DONE entered at edge 2*(N_TERMS-1); done high that cycle.
//   Partial sums stay in [0, x]; clamp is protective only.
//   start held high: new op accepted on edge leaving DONE->IDLE is NOT possible; first
//     accept is the edge after IDLE is reached (one idle cycle minimum between ops).
//   x_in=0: full sequence runs, result=0. rst mid-operation: immediate IDLE, result=0.
// CONFIGURATION
//   LN_SERIES_EARLY_EXIT_EN defined: in TERM, if term==0 -> DONE immediately
//     (later terms are provably 0); latency shrinks accordingly.
//   Undefined: always N_TERMS terms, fixed latency above.
// STRUCTURE
//   Package ln_series_pkg: state enum {IDLE,POW,TERM,DONE}, DATA_W/ADDR_W/ACC_W constants,
//     MAX_TERMS=9.
//   Sub-module ln_term_mac: truncating DATA_W x DATA_W multiply + signed add/sub step.
//   LUT stays outside this block.
// TESTING
//   x=0x8000, N_TERMS=8 -> done at edge 14, result=0x67C2.
//   x=0x0000 -> result=0x0000, done at edge 14.
//   N_TERMS=1, x=0x1234 -> done at edge 0 (DONE entered on the accepting edge), result=0x1234.
//   start pulsed at edges 3 and 7 while busy -> ignored; single done, result unchanged.
//   rst asserted at edge 5 -> busy=0, result=0 same cycle; new start then gives 0x67C2.
//   EARLY_EXIT_EN, x=0x0100 -> term k=2 is 0, done at edge 2; undefined -> edge 14.

Source files
------------

// File: rtl/ln_series_pkg.sv
// ln_series_pkg: shared constants and FSM state type for the ln(1+x) series sequencer
package ln_series_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int ACC_W = DATA_W + 2;
  localparam int MAX_TERMS = 9;
  typedef enum logic [1:0] {IDLE, POW, TERM, DONE} state_t;
endpackage

// File: rtl/ln_term_mac.sv
// ln_term_mac: truncating Q0.DATA_W product folded into a signed accumulator (add or subtract)
module ln_term_mac #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  input  logic signed [DATA_W+1:0] acc,
  input  logic                     sub,
  output logic [DATA_W-1:0]        term,
  output logic signed [DATA_W+1:0] acc_nx
);
  logic [2*DATA_W-1:0] p;
  logic signed [DATA_W+1:0] t;
  assign p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign term = p[2*DATA_W-1:DATA_W];
  assign t = signed'({2'b00, term});
  assign acc_nx = sub ? acc - t : acc + t;
endmodule

// File: rtl/ln_series_ctrl.sv
// ln_series_ctrl: ln(1+x) Maclaurin sequencer driving an external 1/k LUT.
// Define LN_SERIES_EARLY_EXIT_EN to finish as soon as a term truncates to zero.
module ln_series_ctrl
  import ln_series_pkg::*;
#(
  parameter int DATA_W = ln_series_pkg::DATA_W,
  parameter int N_TERMS = 8,
  parameter int ADDR_W = ln_series_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int AW = DATA_W + 2;
  state_t state;
  logic [DATA_W-1:0] x_r, pow, term, sat;
  logic [2*DATA_W-1:0] pp;
  logic signed [AW-1:0] acc, acc_nx;
  logic [3:0] k;
  logic last;
  assign pp = (2*DATA_W)'(pow) * (2*DATA_W)'(x_r);
  ln_term_mac #(.DATA_W(DATA_W)) u_mac (
    .a(pow), .b(coef_data), .acc(acc), .sub(~k[0]), .term(term), .acc_nx(acc_nx)
  );
`ifdef LN_SERIES_EARLY_EXIT_EN
  assign last = (k == 4'(N_TERMS)) || (term == '0);
`else
  assign last = k == 4'(N_TERMS);
`endif
  // partial sums stay within [0, x]; saturation only guards against surprises
  assign sat = acc_nx[AW-1] ? '0 : acc_nx[AW-2] ? '1 : acc_nx[DATA_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_r <= '0;
      pow <= '0;
      acc <= '0;
      k <= '0;
      coef_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_r <= x_in;
          pow <= x_in;
          acc <= signed'({2'b00, x_in});
          k <= 4'd2;
          busy <= 1'b1;
          if (N_TERMS == 1) begin
            state <= DONE;
            done <= 1'b1;
            result <= x_in;
          end else state <= POW;
        end
        POW: begin
          pow <= pp[2*DATA_W-1:DATA_W];
          coef_addr <= ADDR_W'(k - 4'd2);
          state <= TERM;
        end
        TERM: begin
          acc <= acc_nx;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            result <= sat;
          end else begin
            k <= k + 4'd1;
            state <= POW;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ln_series_ctrl.sv
// tb_ln_series_ctrl: randomized checks of ln_series_ctrl against a series-sum reference model
module tb_ln_series_ctrl;
  logic clk = 1'b0;
  logic rst, start, start1;
  logic [15:0] x_in, x1, coef_data, coef_data1, result, result1;
  logic [2:0] coef_addr, coef_addr1;
  logic busy, done, busy1, done1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign coef_data = 16'(32'd65536 / (32'(coef_addr) + 32'd2));
  assign coef_data1 = 16'(32'd65536 / (32'(coef_addr1) + 32'd2));

  ln_series_ctrl #(.N_TERMS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy), .done(done), .result(result)
  );
  ln_series_ctrl #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_in(x1), .coef_addr(coef_addr1),
    .coef_data(coef_data1), .busy(busy1), .done(done1), .result(result1)
  );

  // ln(1+x) partial sum with Q0.16 truncation; e = edge (after accept) at which done rises
  function automatic void model(input logic [15:0] x, input int n, output logic [15:0] r, output int e);
    longint p, s, t;
    p = x;
    s = x;
    e = 0;
    for (int kk = 2; kk <= n; kk++) begin
      p = (p * longint'(x)) >> 16;
      t = (p * (65536 / kk)) >> 16;
      s = (kk % 2 == 0) ? s - t : s + t;
      e = 2 * (kk - 1);
`ifdef LN_SERIES_EARLY_EXIT_EN
      if (t == 0) break;
`endif
    end
    r = s < 0 ? 16'h0 : s > 65535 ? 16'hFFFF : 16'(s);
  endfunction

  task automatic run_op(input logic [15:0] x, output logic [15:0] r, output int e);
    @(negedge clk);
    x_in = x;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = -1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        e = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    r = result;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    x_in = '0;
    x1 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, result, coef_addr} !== 21'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%h addr=%0d, need all 0", busy, done, result, coef_addr);
    end
    tests++;
    if ({busy1, done1, result1} !== 18'd0) begin
      fails++;
      $display("FAIL reset_n1: busy=%b done=%b result=%h, need 0", busy1, done1, result1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    logic [15:0] r, mr;
    int e, me;
    run_op(16'h8000, r, e);
    tests++;
    if (r !== 16'h67C2 || e !== 14) begin
      fails++;
      $display("FAIL half: result=%h edge=%0d, need 67C2 edge 14", r, e);
    end
    run_op(16'h0000, r, e);
    model(16'h0000, 8, mr, me);
    tests++;
    if (r !== 16'h0000 || e !== me) begin
      fails++;
      $display("FAIL zero: result=%h edge=%0d, need 0000 edge %0d", r, e, me);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_early_exit();
    logic [15:0] r;
    int e;
`ifdef LN_SERIES_EARLY_EXIT_EN
    int need = 2;
`else
    int need = 14;
`endif
    run_op(16'h0100, r, e);
    tests++;
    if (r !== 16'h0100 || e !== need) begin
      fails++;
      $display("FAIL early_exit: result=%h edge=%0d, need 0100 edge %0d", r, e, need);
    end
  endtask

  task automatic test_n1();
    @(negedge clk);
    x1 = 16'h1234;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    tests++;
    if (done1 !== 1'b1 || result1 !== 16'h1234) begin
      fails++;
      $display("FAIL n1: done=%b result=%h, need 1 1234 at edge 0", done1, result1);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done1 !== 1'b0) begin
      fails++;
      $display("FAIL n1_pulse: done=%b, need 0", done1);
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [15:0] prev;
    prev = result;
    @(negedge clk);
    x_in = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 7) begin
        x_in = 16'($urandom);
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) ndone++;
      if (c == 13) begin
        tests++;
        if (result !== prev) begin
          fails++;
          $display("FAIL ignore_hold: result=%h before done, need %h", result, prev);
        end
      end
    end
    tests++;
    if (ndone !== 1 || result !== 16'h67C2) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d result=%h, need 1 67C2", ndone, result);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] r;
    int e;
    @(negedge clk);
    x_in = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || result !== 16'h0) begin
      fails++;
      $display("FAIL rst_mid: busy=%b result=%h, need 0 0000", busy, result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h8000, r, e);
    tests++;
    if (r !== 16'h67C2 || e !== 14) begin
      fails++;
      $display("FAIL after_rst: result=%h edge=%0d, need 67C2 edge 14", r, e);
    end
  endtask

  task automatic test_random();
    logic [15:0] x, r, mr;
    int e, me;
    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom);
      if (i < 3) x = 16'($urandom_range(0, 255));
      model(x, 8, mr, me);
      run_op(x, r, e);
      tests++;
      if (r !== mr || e !== me) begin
        fails++;
        $display("FAIL random x=%h: result=%h edge=%0d, need %h edge %0d", x, r, e, mr, me);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got[$];
    logic [15:0] mr;
    int me;
    model(16'h8000, 8, mr, me);
    @(negedge clk);
    x_in = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c <= 31; c++) begin
      if (done) got.push_back(c);
      if (c == 31) start = 1'b0;
      @(posedge clk);
      #1;
    end
    tests++;
    if (got.size() !== 2 || got[0] !== me || got[1] !== 2 * me + 2) begin
      fails++;
      $display("FAIL back_to_back: %0d dones first=%0d second=%0d, need %0d and %0d",
               got.size(), got.size() > 0 ? got[0] : -1, got.size() > 1 ? got[1] : -1, me, 2 * me + 2);
    end
    tests++;
    if (result !== mr) begin
      fails++;
      $display("FAIL back_to_back_result: result=%h, need %h", result, mr);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_early_exit();
    test_n1();
    test_ignore_start();
    test_rst_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
